// File: rtl/vga_rect_plotter.sv
// vga_rect_plotter: raster pixel-stream generator for filled rectangles and screen clears, clipped to the visible area
module vga_rect_plotter #(
  parameter int X_WIDTH = 8,
  parameter int Y_WIDTH = 7,
  parameter int COLOUR_WIDTH = 3,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode,
  input  logic [X_WIDTH-1:0]      x0,
  input  logic [Y_WIDTH-1:0]      y0,
  input  logic [X_WIDTH-1:0]      w,
  input  logic [Y_WIDTH-1:0]      h,
  input  logic [COLOUR_WIDTH-1:0] colour_in,
  output logic                    busy,
  output logic                    done,
  output logic [X_WIDTH-1:0]      x_out,
  output logic [Y_WIDTH-1:0]      y_out,
  output logic [COLOUR_WIDTH-1:0] colour_out,
  output logic                    plot
);
  typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;
  state_t state, state_next;
  logic [X_WIDTH-1:0] jx, jw, dx, nw;
  logic [Y_WIDTH-1:0] jy, jh, dy, nh;
  logic [COLOUR_WIDTH-1:0] jc;
  logic [X_WIDTH:0] sx;
  logic [Y_WIDTH:0] sy;
  logic end_x, end_y, in_range;
  always_comb begin
    nw = mode ? X_WIDTH'(X_MAX + 1) : w;
    nh = mode ? Y_WIDTH'(Y_MAX + 1) : h;
    sx = {1'b0, jx} + {1'b0, dx};
    sy = {1'b0, jy} + {1'b0, dy};
    end_x = dx == jw - X_WIDTH'(1);
    end_y = dy == jh - Y_WIDTH'(1);
    in_range = sx <= (X_WIDTH+1)'(X_MAX) && sy <= (Y_WIDTH+1)'(Y_MAX);
    state_next = state;
    if (state == IDLE && start) state_next = (nw == '0 || nh == '0) ? FINISH : DRAW;
    else if (state == DRAW && end_x && end_y) state_next = FINISH;
    else if (state == FINISH) state_next = IDLE;
  end
  // outputs lag the state by one edge, so busy/plot line up with the pixel they describe
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      {busy, done, plot} <= '0;
      {x_out, y_out, colour_out} <= '0;
      {jx, jy, jw, jh, jc, dx, dy} <= '0;
    end else begin
      state <= state_next;
      busy <= state == DRAW;
      plot <= state == DRAW && in_range;
      done <= state == FINISH;
      if (state == IDLE && start) begin
        jx <= mode ? '0 : x0;
        jy <= mode ? '0 : y0;
        jw <= nw;
        jh <= nh;
        jc <= colour_in;
        dx <= '0;
        dy <= '0;
      end
      if (state == DRAW) begin
        x_out <= sx[X_WIDTH-1:0];
        y_out <= sy[Y_WIDTH-1:0];
        colour_out <= jc;
        dx <= end_x ? '0 : dx + X_WIDTH'(1);
        dy <= end_x ? dy + Y_WIDTH'(1) : dy;
      end
    end
  end
endmodule

// File: tb/tb_vga_rect_plotter.sv
// tb_vga_rect_plotter: directed self-checking bench for vga_rect_plotter
module tb_vga_rect_plotter;
  logic clock = 0, reset = 1, start = 0, mode = 0;
  logic [7:0] x0 = 0, w = 0, x_out;
  logic [6:0] y0 = 0, h = 0, y_out;
  logic [2:0] colour_in = 0, colour_out;
  logic busy, done, plot;
  int checks = 0, failures = 0;

  vga_rect_plotter dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .x0(x0), .y0(y0), .w(w), .h(h), .colour_in(colour_in),
    .busy(busy), .done(done), .x_out(x_out), .y_out(y_out),
    .colour_out(colour_out), .plot(plot)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic go(input logic m, input logic [7:0] xx, input logic [6:0] yy,
                    input logic [7:0] ww, input logic [6:0] hh, input logic [2:0] cc);
    @(negedge clock);
    mode = m; x0 = xx; y0 = yy; w = ww; h = hh; colour_in = cc; start = 1;
    step;
    start = 0;
  endtask

  initial begin
    int ex[4], ey[4], nd;
    start = 1;
    repeat (3) step;
    check("rst_outs", {busy, done, plot, x_out, y_out, colour_out}, 0);
    reset = 0;
    start = 0;
    repeat (2) step;
    check("rst_start_ignored", {busy, done, plot}, 0);

    ex = '{10, 11, 10, 11};
    ey = '{5, 5, 6, 6};
    go(0, 10, 5, 2, 2, 3'b101);
    check("t1_busy_lag", busy, 0);
    for (int k = 0; k < 4; k++) begin
      step;
      check("t1_pix", {busy, done, plot, x_out, y_out, colour_out}, {3'b101, 8'(ex[k]), 7'(ey[k]), 3'd5});
    end
    step;
    check("t1_done", {busy, done, plot}, 3'b010);
    step;
    check("t1_done_end", {busy, done, plot}, 0);

    go(0, 3, 3, 0, 3, 1);
    check("t2_no_busy", {busy, plot}, 0);
    step;
    check("t2_done", {busy, done, plot}, 3'b010);
    step;
    check("t2_done_end", {busy, done, plot}, 0);

    go(0, 158, 118, 4, 4, 6);
    for (int k = 0; k < 16; k++) begin
      step;
      check("t3_clip", {busy, plot, x_out, y_out},
            {1'b1, 1'((158 + k % 4) <= 159 && (118 + k / 4) <= 119), 8'(158 + k % 4), 7'(118 + k / 4)});
    end
    step;
    check("t3_done", {busy, done, plot}, 3'b010);

    go(1, 55, 66, 3, 2, 0);
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) begin
        step;
        check("t4_clear", {busy, plot, x_out, y_out, colour_out}, {2'b11, 8'(x), 7'(y), 3'd0});
      end
    step;
    check("t4_done", {busy, done, plot}, 3'b010);
    step;

    ex = '{20, 21, 20, 21};
    ey = '{30, 30, 31, 31};
    go(0, 20, 30, 2, 2, 2);
    nd = 0;
    for (int k = 0; k < 4; k++) begin
      step;
      check("t5_pix", {plot, x_out, y_out, colour_out}, {1'b1, 8'(ex[k]), 7'(ey[k]), 3'd2});
      if (k == 0) begin
        start = 1; mode = 1; x0 = 90; y0 = 9; w = 7; h = 7; colour_in = 7;
      end
      if (k == 1) start = 0;
      nd += done;
    end
    for (int k = 0; k < 4; k++) begin
      step;
      nd += done;
    end
    check("t5_one_done", nd, 1);
    check("t5_idle", {busy, plot}, 0);

    go(0, 1, 1, 4, 4, 7);
    step;
    step;
    reset = 1;
    step;
    reset = 0;
    check("t6_abort", {busy, done, plot, x_out, y_out, colour_out}, 0);
    nd = 0;
    repeat (3) begin
      step;
      nd += done + busy;
    end
    check("t6_no_done", nd, 0);
    go(0, 2, 3, 1, 1, 4);
    step;
    check("t6_fresh_pix", {busy, plot, x_out, y_out, colour_out}, {2'b11, 8'd2, 7'd3, 3'd4});
    step;
    check("t6_fresh_done", {busy, done, plot}, 3'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_rect_plotter.md
Name: vga_rect_plotter

Overview:
- Parametrised pixel-stream generator that sits between user control logic (switch/key registers, FSMs) and the vga_adapter plot interface.
- On a start strobe it latches an origin, size, colour and mode, then emits one pixel per cycle in raster order on x_out/y_out/colour_out/plot.
- Supports two modes: filled rectangle, and full-screen clear.
- Clips pixels outside the screen so callers never write out of range.

Parameters:
X_WIDTH, 8, width of x coordinate, x_out and w
Y_WIDTH, 7, width of y coordinate, y_out and h
COLOUR_WIDTH, 3, width of colour_in and colour_out
X_MAX, 159, largest visible x; pixels with x > X_MAX are clipped
Y_MAX, 119, largest visible y; pixels with y > Y_MAX are clipped

Ports:
clock  in  1  system clock; all state changes on its rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
mode  in  1  0 = rectangle fill; 1 = clear screen (x0/y0/w/h ignored)
x0  in  X_WIDTH  rectangle origin x
y0  in  Y_WIDTH  rectangle origin y
w  in  X_WIDTH  rectangle width in pixels
h  in  Y_WIDTH  rectangle height in pixels
colour_in  in  COLOUR_WIDTH  fill colour
busy  out  1  high while a job is in progress
done  out  1  one-cycle pulse at job end
x_out  out  X_WIDTH  pixel x to adapter
y_out  out  Y_WIDTH  pixel y to adapter
colour_out  out  COLOUR_WIDTH  pixel colour to adapter
plot  out  1  write enable to adapter

Behaviour:
- Clock port is named `clock` and reset port is named `reset`. There is one clock. Reset is synchronous and active-high and takes priority over all other inputs.
- Reset values: state = IDLE; busy, done, plot, x_out, y_out, colour_out = 0; internal counters dx, dy = 0.
- All outputs are registered.
- FSM states are IDLE, DRAW and FINISH.
- IDLE:
  - On start=1, latch the job and enter DRAW, setting busy=1 on the next edge.
  - Mode 0 latches x0, y0, w, h and colour_in.
  - Mode 1 latches origin (0,0), width X_MAX+1, height Y_MAX+1 and colour_in.
  - If the latched w==0 or h==0, go directly to FINISH and emit no pixels.
- DRAW:
  - Each cycle outputs pixel (x0+dx, y0+dy).
  - The sums are computed at X_WIDTH+1 and Y_WIDTH+1 bits; x_out and y_out carry the truncated low bits.
  - plot=1 only if x0+dx <= X_MAX and y0+dy <= Y_MAX. Otherwise plot=0, but the cycle is still consumed, so timing is fixed at w*h cycles.
  - dx increments each cycle. When dx==w-1, dx wraps to 0 and dy increments.
  - After the pixel with dx==w-1 and dy==h-1, go to FINISH.
- FINISH: lasts one cycle with busy=0, plot=0 and done=1, then returns to IDLE with done=0.
- Latency: start sampled at edge N drives the first pixel with plot valid after edge N+1. The last pixel appears after edge N+w*h. The done pulse appears after edge N+w*h+1.
- start while busy, or in FINISH, is ignored; there is no queueing. start in the same cycle as reset is ignored.
- Latched parameters are stable for the whole job. Changes on x0/y0/w/h/colour_in/mode during busy have no effect.
- Reset during DRAW aborts immediately: plot drops on the next edge and no done pulse is generated.
- colour_out holds the latched colour throughout DRAW. x_out and y_out hold their last values in IDLE and FINISH.

Test Plan:
- Reset, then start with mode=0, x0=10, y0=5, w=2, h=2, colour=3'b101 -> four plot cycles on consecutive edges at (10,5),(11,5),(10,6),(11,6), colour 5; done pulses 1 cycle later; busy high exactly 4 cycles.
- start with w=0, h=3 -> no plot cycles; done pulses after edge N+1; busy never asserted.
- start with x0=158, y0=118, w=4, h=4 -> 16 DRAW cycles with plot=1 only at (158,118),(159,118),(158,119),(159,119); the other 12 cycles have plot=0.
- start with mode=1, colour=3'b000 -> 19200 plot cycles covering (0,0)..(159,119) in raster order, each pixel exactly once; then done.
- Second start pulse issued mid-job with different parameters -> ignored; the first job completes unchanged, and there is exactly one done pulse.
- Assert reset on the 3rd DRAW cycle of a 4x4 job -> next edge: plot=0, busy=0, all outputs 0, no done pulse; a fresh start then runs normally.
